// File: rtl/sifh_hist_reader.sv
// Histogram RAM readout: scans every bin of every pixel, reports the peak bin/count
// per pixel on a valid/ready stream, optionally zeroing each bin behind the read.
module sifh_hist_reader #(
   parameter int NB       = 8,
   parameter int PIXELS   = 4,
   parameter int COUNT_W  = 8,
   parameter int PIX_W    = 2,
   parameter int RAM_ADDR = 10
) (
   input  logic                i_clk,
   input  logic                i_res,
   input  logic                i_start,
   input  logic                i_clear_en,
   output logic                o_busy,
   output logic                o_done,
   output logic [RAM_ADDR-1:0] o_raddr,
   output logic                o_ren,
   input  logic [COUNT_W-1:0]  i_rdata,
   output logic [RAM_ADDR-1:0] o_waddr,
   output logic                o_wen,
   output logic [COUNT_W-1:0]  o_wdata,
   output logic                o_res_valid,
   input  logic                i_res_ready,
   output logic [PIX_W-1:0]    o_res_pixel,
   output logic [NB-1:0]       o_res_bin,
   output logic [COUNT_W-1:0]  o_res_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic [NB-1:0]    BIN_LAST = '1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

   logic [1:0]          r_state;
   logic [PIX_W-1:0]    r_pix;
   logic [NB-1:0]       r_bin;
   logic                r_clr;
   logic                r_pvld;
   logic [RAM_ADDR-1:0] r_paddr;
   logic                r_first;
   logic [COUNT_W-1:0]  r_max_cnt;
   logic [NB-1:0]       r_max_bin;
   logic                r_busy;
   logic                r_done;
   logic                r_res_valid;
   logic [NB-1:0]       r_res_bin;
   logic [COUNT_W-1:0]  r_res_count;

   logic                w_take;
   logic [COUNT_W-1:0]  w_cnt;
   logic [NB-1:0]       w_mbin;

   // Strict compare keeps the lowest bin on ties; first sample of a pixel always loads.
   assign w_take = r_pvld && (r_first || (i_rdata > r_max_cnt));
   assign w_cnt  = w_take ? i_rdata : r_max_cnt;
   assign w_mbin = w_take ? r_paddr[NB-1:0] : r_max_bin;

   always_ff @(posedge i_clk) begin
      if (i_res) begin
         r_state     <= S_IDLE;
         r_pix       <= '0;
         r_bin       <= '0;
         r_clr       <= 1'b0;
         r_pvld      <= 1'b0;
         r_paddr     <= '0;
         r_first     <= 1'b0;
         r_max_cnt   <= '0;
         r_max_bin   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_bin   <= '0;
         r_res_count <= '0;
      end else begin
         r_done <= 1'b0;
         r_pvld <= (r_state == S_SCAN);
         if (r_state == S_SCAN) r_paddr <= {r_pix, r_bin};
         if (r_pvld) begin
            r_max_cnt <= w_cnt;
            r_max_bin <= w_mbin;
            r_first   <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               // A start coinciding with the done pulse is dropped.
               if (i_start && !r_done) begin
                  r_clr   <= i_clear_en;
                  r_pix   <= '0;
                  r_bin   <= '0;
                  r_first <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_bin <= r_bin + 1'b1;
               if (r_bin == BIN_LAST) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               r_res_valid <= 1'b1;
               r_res_bin   <= w_mbin;
               r_res_count <= w_cnt;
               r_state     <= S_OUT;
            end
            default: begin
               if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  if (r_pix == PIX_LAST) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_pix   <= r_pix + 1'b1;
                     r_bin   <= '0;
                     r_first <= 1'b1;
                     r_state <= S_SCAN;
                  end
               end
            end
         endcase
      end
   end

   assign o_ren       = (r_state == S_SCAN);
   assign o_raddr     = o_ren ? {r_pix, r_bin} : '0;
   // Clear write trails the read by one address, so it never collides with it.
   assign o_wen       = r_pvld && r_clr;
   assign o_waddr     = r_paddr;
   assign o_wdata     = '0;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_res_valid = r_res_valid;
   assign o_res_pixel = r_pix;
   assign o_res_bin   = r_res_bin;
   assign o_res_count = r_res_count;

endmodule

// File: tb/tb_sifh_hist_reader.sv
// Bench for sifh_hist_reader: behavioural RAM plus a per-pixel max-search model.
module tb_sifh_hist_reader;
   localparam int NB = 8, PIXELS = 4, COUNT_W = 8, PIX_W = 2, RAM_ADDR = 10;
   localparam int NBINS = 256, DEPTH = 1024;

   logic clk = 1'b0, res = 1'b1, start = 1'b0, clear_en = 1'b0, res_ready = 1'b1;
   logic busy, done, ren, wen, res_valid;
   logic [RAM_ADDR-1:0] raddr, waddr;
   logic [COUNT_W-1:0]  rdata, wdata, res_count;
   logic [PIX_W-1:0]    res_pixel;
   logic [NB-1:0]       res_bin;

   logic [7:0] mem [DEPTH];
   logic       pl_we = 1'b0;
   logic [9:0] pl_addr = '0;
   logic [7:0] pl_data = '0;

   int checks = 0, errors = 0;
   int gold [DEPTH];
   int exp_bin [PIXELS];
   int exp_cnt [PIXELS];

   sifh_hist_reader #(.NB(NB), .PIXELS(PIXELS), .COUNT_W(COUNT_W), .PIX_W(PIX_W),
                      .RAM_ADDR(RAM_ADDR)) dut (
      .i_clk(clk), .i_res(res), .i_start(start), .i_clear_en(clear_en),
      .o_busy(busy), .o_done(done), .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata),
      .o_waddr(waddr), .o_wen(wen), .o_wdata(wdata), .o_res_valid(res_valid),
      .i_res_ready(res_ready), .o_res_pixel(res_pixel), .o_res_bin(res_bin),
      .o_res_count(res_count));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ren) rdata <= mem[raddr];
      if (wen) mem[waddr] <= wdata;
      if (pl_we) mem[pl_addr] <= pl_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int mode);
      int v;
      for (int a = 0; a < DEPTH; a++) begin
         int p, b;
         p = a / NBINS;
         b = a % NBINS;
         if (mode == 0) begin
            case (p)
               0: v = (b == 37) ? 200 : 5;
               1: v = (b == 255) ? 255 : int'($urandom_range(0, 254));
               2: v = (b == 10 || b == 90) ? 77 : int'($urandom_range(0, 3));
               default: v = 0;
            endcase
         end else if (mode == 1) begin
            v = int'($urandom_range(0, 255));
         end else begin
            case ($urandom_range(0, 3))
               0: v = 0;
               1: v = 255;
               default: v = int'($urandom_range(0, 7));
            endcase
         end
         gold[a] = v;
         pl_we = 1'b1; pl_addr = 10'(a); pl_data = 8'(v);
         step();
      end
      pl_we = 1'b0;
      step();
   endtask

   // Peak per pixel: highest count, earliest bin on ties.
   task automatic build_exp();
      for (int p = 0; p < PIXELS; p++) begin
         int best, bb;
         best = -1; bb = 0;
         for (int b = 0; b < NBINS; b++)
            if (gold[p*NBINS + b] > best) begin best = gold[p*NBINS + b]; bb = b; end
         exp_bin[p] = bb;
         exp_cnt[p] = best;
      end
   endtask

   task automatic run_frame(input bit clr, input int stall_pix, input int stall_len,
                            input bit check_len);
      int pix, busy_cyc, cyc, prev_raddr;
      bit prev_ren, fin;
      pix = 0; busy_cyc = 0; cyc = 0; prev_raddr = 0; prev_ren = 1'b0; fin = 1'b0;
      build_exp();
      clear_en = clr; start = 1'b1;
      step();
      start = 1'b0;
      while (!fin && cyc < 5000) begin
         cyc++;
         start = (cyc == 50);
         if (busy) busy_cyc++;
         if (wen) begin
            chk("wen_addr_trails_read", 32'(waddr), 32'(prev_raddr));
            chk("wen_after_ren", 32'(prev_ren), 1);
            chk("wen_with_clear_off", 32'(clr), 1);
         end
         if (res_valid) begin
            chk("res_pixel", 32'(res_pixel), 32'(pix));
            chk("res_bin", 32'(res_bin), 32'(exp_bin[pix]));
            chk("res_count", 32'(res_count), 32'(exp_cnt[pix]));
            if (pix == stall_pix && stall_len > 0) begin
               res_ready = 1'b0;
               for (int s = 0; s < stall_len; s++) begin
                  step();
                  cyc++;
                  chk("stall_valid", 32'(res_valid), 1);
                  chk("stall_ren", 32'(ren), 0);
                  chk("stall_wen", 32'(wen), 0);
                  chk("stall_pixel", 32'(res_pixel), 32'(pix));
                  chk("stall_bin", 32'(res_bin), 32'(exp_bin[pix]));
                  chk("stall_count", 32'(res_count), 32'(exp_cnt[pix]));
               end
               res_ready = 1'b1;
            end
            pix++;
         end
         if (done) begin
            chk("done_after_all_pixels", 32'(pix), PIXELS);
            chk("busy_low_at_done", 32'(busy), 0);
            fin = 1'b1;
         end
         prev_raddr = int'(raddr);
         prev_ren = ren;
         if (!fin) step();
      end
      start = 1'b0;
      chk("frame_completed", 32'(fin), 1);
      if (check_len) chk("busy_cycles", 32'(busy_cyc), PIXELS*(NBINS+2));
   endtask

   task automatic check_ram(input bit zero, input string tag);
      int bad;
      bad = 0;
      for (int a = 0; a < DEPTH; a++)
         if (mem[a] !== (zero ? 8'd0 : 8'(gold[a]))) bad++;
      chk(tag, 32'(bad), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_ren"}, 32'(ren), 0);
      chk({tag, "_wen"}, 32'(wen), 0);
      chk({tag, "_raddr"}, 32'(raddr), 0);
      chk({tag, "_waddr"}, 32'(waddr), 0);
      chk({tag, "_valid"}, 32'(res_valid), 0);
      chk({tag, "_pixel"}, 32'(res_pixel), 0);
      chk({tag, "_bin"}, 32'(res_bin), 0);
      chk({tag, "_count"}, 32'(res_count), 0);
      chk({tag, "_wdata"}, 32'(wdata), 0);
   endtask

   initial begin
      bit found;
      res = 1'b1;
      repeat (3) step();
      check_outputs_zero("reset");
      res = 1'b0;
      step();

      // Directed peaks: bin37, bin255 saturated, tie at 10/90, all-zero pixel.
      fill(0);
      run_frame(1'b0, -1, 0, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_at_done_ignored", 32'(busy), 0);
      step();
      chk("start_at_done_no_read", 32'(ren), 0);
      check_ram(1'b0, "ram_unchanged_clear_off");

      // Random contents, clear-on-read, backpressure on pixel 1.
      fill(1);
      run_frame(1'b1, 1, 20, 1'b0);
      check_ram(1'b1, "ram_zero_after_clear");

      // Reset in the middle of pixel 1.
      fill(2);
      clear_en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (ren && raddr == 10'(NBINS + 100)) found = 1'b1;
         else step();
      end
      chk("reached_reset_point", 32'(found), 1);
      res = 1'b1;
      step();
      check_outputs_zero("midscan_reset");
      res = 1'b0;
      step();
      chk("no_write_after_reset", 32'(wen), 0);
      chk("idle_after_reset", 32'(busy), 0);
      for (int a = 0; a < DEPTH; a++) gold[a] = int'(mem[a]);
      run_frame(1'b0, -1, 0, 1'b1);
      check_ram(1'b0, "ram_unchanged_after_rerun");

      // Saturated values and dense ties, with clear.
      fill(2);
      run_frame(1'b1, -1, 0, 1'b1);
      check_ram(1'b1, "ram_zero_after_clear2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sifh_hist_reader.md
Name: sifh_hist_reader

Overview:
- Readout side of the SiFH histogram RAM. The histogram-building FSM fills the RAM with per-pixel photon-count histograms.
- This block drains the RAM: for each pixel it scans every bin, finds the peak bin (ToF estimate) and its count, and emits one result per pixel on a valid/ready stream.
- It can optionally clear each bin to zero as it is read, so the RAM is ready for the next acquisition without a separate reset pass.
- It sits between the histogram RAM's read/write ports and the depth-result packer.

Parameters:
- NB, 8, bin address width; bins per pixel = 2**NB.
- PIXELS, 4, pixels stored per RAM.
- COUNT_W, 8, bin count width; equals the RAM data width.
- PIX_W, 2, pixel index width, clog2(PIXELS).
- RAM_ADDR, 10, RAM address width, PIX_W+NB.

Ports:
- clk  in  1  clock.
- res  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins readout of all pixels.
- clear_en  in  1  sampled at start; 1 = zero each bin after reading it.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel result is accepted.
- raddr  out  RAM_ADDR  RAM read address, {pixel, bin}.
- ren  out  1  RAM read enable.
- rdata  in  COUNT_W  RAM read data, valid 1 cycle after ren.
- waddr  out  RAM_ADDR  RAM write address (clear).
- wen  out  1  RAM write enable (clear).
- wdata  out  COUNT_W  RAM write data, always 0.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream ready.
- res_pixel  out  PIX_W  pixel index of the result.
- res_bin  out  NB  peak bin.
- res_count  out  COUNT_W  peak count.

Behaviour:
- Reset:
  - res=1 on any clk edge forces state IDLE.
  - All outputs go to 0: busy, done, ren, wen, raddr, waddr, res_valid, res_pixel, res_bin, res_count.
  - Internal pixel counter, bin counter and max registers clear.
  - Reset mid-scan abandons the scan. A partially cleared RAM is acceptable and no write is issued after reset.
- States:
  - IDLE:
    - start=1 latches clear_en, sets pixel=0 and bin=0, and moves to SCAN.
  - SCAN:
    - ren=1, raddr={pixel,bin}, bin increments every cycle.
    - The pipeline register holds the previous address and a valid flag.
    - When the valid flag is set, rdata is compared against max_count. Strictly greater updates max_count and max_bin, so on a tie the lowest bin wins.
    - The first valid sample of a pixel loads max unconditionally.
    - If clear is latched, wen=1 with waddr equal to the previous address, one cycle after the read.
    - When bin=2**NB-1 has been issued, go to DRAIN.
  - DRAIN:
    - ren=0; consume the last rdata (compare, plus clear write if latched).
    - Go to OUT. res_valid rises on the cycle OUT is entered.
  - OUT:
    - res_valid=1; res_pixel, res_bin and res_count are held stable until res_valid && res_ready.
    - On handshake: if pixel=PIXELS-1, go to IDLE with done=1 for one cycle and busy=0. Otherwise pixel+1, bin=0, go to SCAN.
- Latency:
  - Per pixel, the first res_valid appears 2**NB+1 cycles after entering SCAN.
  - With res_ready held high, each pixel takes 2**NB+2 cycles.
  - Total busy time is PIXELS*(2**NB+2) cycles.
- Start handling:
  - start is ignored while busy.
  - start arriving in the same cycle as done is ignored; the block returns to IDLE first.
- Arithmetic:
  - Comparison is unsigned COUNT_W.
  - A saturated count (all ones) is handled as a normal value.
  - The bin counter wraps to 0 on the pixel change; no carry into pixel.
  - An all-zero histogram gives res_bin=0 and res_count=0.
- RAM access rules:
  - Reads and clear-writes never address the same location in the same cycle, because the write trails the read by one address.
  - No write is ever issued when the latched clear_en is 0.
- Backpressure: res_ready low in OUT stalls the block indefinitely with ren=0 and wen=0.

Test Plan:
- Peak search, clear off: preload pixel0 bin37=200, all else 5; start, clear_en=0, ready=1 -> pixel0 result bin=37 count=200; RAM unchanged; done 4*258 cycles after busy rises.
- Tie rule: pixel2 bins 10 and 90 both 77, max elsewhere 3 -> res_pixel=2, bin=10, count=77.
- Clear-on-read: random RAM, clear_en=1 -> results match the golden model; afterwards all 1024 locations read 0; every wen has waddr equal to raddr of the previous cycle.
- Backpressure: res_ready low for 20 cycles at pixel1 OUT -> outputs stable; ren=0 and wen=0 during the stall; completes after ready rises.
- Edge values: all-zero pixel3 -> bin 0, count 0; bin255=255 -> bin 255, count 255.
- Reset mid-scan at pixel1 bin100 -> next cycle all outputs 0 and state IDLE; a fresh start reproduces the full correct results.
